// File: rtl/riscv_dm_pkg.sv
// Shared RISC-V Debug Module definitions: abstract command layouts, the
// abstractcs register layout, cmderr codes and Access Register regno ranges.
package riscv_dm_pkg;

  // COMMAND register: command type plus type-specific control field.
  typedef struct packed {
    logic [7:0]  cmdtype;
    logic [23:0] control;
  } command_t;

  // Control field layout for the Access Register command (cmdtype 0).
  typedef struct packed {
    logic        zero0;
    logic [2:0]  aarsize;
    logic        aarpostincrement;
    logic        postexec;
    logic        transfer;
    logic        write;
    logic [15:0] regno;
  } access_register_t;

  // ABSTRACTCS register layout; busy and cmderr are owned by the sequencer.
  typedef struct packed {
    logic [2:0]  zero3;
    logic [4:0]  progbufsize;
    logic [10:0] zero2;
    logic        busy;
    logic        relaxedpriv;
    logic [2:0]  cmderr;
    logic [3:0]  zero1;
    logic [3:0]  datacount;
  } abstractcs_t;

  localparam logic [7:0] CMDTYPE_ACCESS_REG = 8'd0;

  localparam logic [2:0] CMDERR_NONE       = 3'd0;
  localparam logic [2:0] CMDERR_BUSY       = 3'd1;
  localparam logic [2:0] CMDERR_NOTSUP     = 3'd2;
  localparam logic [2:0] CMDERR_EXCEPT     = 3'd3;
  localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;

  localparam logic [2:0] AARSIZE_32 = 3'd2;
  localparam logic [2:0] AARSIZE_64 = 3'd3;

  localparam logic [15:0] REGNO_CSR_LAST  = 16'h0FFF;
  localparam logic [15:0] REGNO_GPR_FIRST = 16'h1000;
  localparam logic [15:0] REGNO_GPR_LAST  = 16'h101F;

  // True when regno names a CSR or one of the 32 GPRs.
  function automatic logic regno_supported(input logic [15:0] regno);
    return (regno <= REGNO_CSR_LAST) ||
           ((regno >= REGNO_GPR_FIRST) && (regno <= REGNO_GPR_LAST));
  endfunction

endpackage

// File: rtl/riscv_dm_abstract_cmd.sv
// Abstract-command sequencer of the RISC-V Debug Module. Accepts COMMAND
// writes and autoexec re-issues, validates Access Register commands, runs the
// hart register handshake and the program-buffer execution handshake, and
// owns abstractcs.busy / abstractcs.cmderr. All outputs are registered.
module riscv_dm_abstract_cmd
  import riscv_dm_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            dmactive_i,
  input  logic            halted_i,
  input  logic            cmd_valid_i,
  input  logic [31:0]     cmd_i,
  input  logic            autoexec_i,
  input  logic [2:0]      cmderr_clr_i,
  output logic            busy_o,
  output logic [2:0]      cmderr_o,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] data_o,
  output logic [1:0]      data_we_o,
  output logic            reg_req_o,
  output logic            reg_we_o,
  output logic [15:0]     reg_addr_o,
  output logic [XLEN-1:0] reg_wdata_o,
  input  logic            reg_ack_i,
  input  logic [XLEN-1:0] reg_rdata_i,
  input  logic            reg_err_i,
  output logic            exec_req_o,
  input  logic            exec_done_i,
  input  logic            exec_exc_i
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REG,
    ST_EXEC
  } state_e;

  // Keeps the low 32 bits of a hart-width word (all bits when XLEN is 32).
  localparam logic [XLEN-1:0] WORD_MASK = XLEN'(64'h0000_0000_FFFF_FFFF);

  state_e            state_q;
  logic              busy_q;
  logic [2:0]        cmderr_q;
  command_t          last_cmd_q;
  logic              reg_req_q;
  logic              reg_we_q;
  logic [15:0]       reg_addr_q;
  logic [XLEN-1:0]   reg_wdata_q;
  logic              exec_req_q;
  logic [XLEN-1:0]   data_q;
  logic [1:0]        data_we_q;

  logic              launch;
  command_t          launch_cmd;
  access_register_t  launch_ar;
  access_register_t  cur_ar;
  logic [2:0]        cmderr_cleared;
  logic [2:0]        check_err;
  logic              size_ok;
  logic              launch_size64;
  logic              cur_size64;

  // Launch decode: pick the command to run, apply this cycle's W1C clear,
  // and classify the command in priority order.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    launch         = cmd_valid_i | autoexec_i;
    launch_cmd     = cmd_valid_i ? command_t'(cmd_i) : last_cmd_q;
    launch_ar      = access_register_t'(launch_cmd.control);
    cur_ar         = access_register_t'(last_cmd_q.control);
    cmderr_cleared = cmderr_q & ~cmderr_clr_i;
    launch_size64  = (launch_ar.aarsize == AARSIZE_64);
    cur_size64     = (cur_ar.aarsize == AARSIZE_64);
    size_ok        = (launch_ar.aarsize == AARSIZE_32) ||
                     (launch_size64 && (XLEN == 64));
    check_err      = CMDERR_NONE;
    if (launch_cmd.cmdtype != CMDTYPE_ACCESS_REG) begin
      check_err = CMDERR_NOTSUP;
    end else if (!halted_i) begin
      check_err = CMDERR_HALTRESUME;
    end else if (launch_ar.transfer &&
                 (!size_ok || !regno_supported(launch_ar.regno))) begin
      check_err = CMDERR_NOTSUP;
    end
  end

  // Sequencer FSM with all handshake and status outputs registered.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      // NOTE: last_cmd is a plain register, not a memory, so it is reset
      // along with the rest of the state.
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      cmderr_q    <= CMDERR_NONE;
      last_cmd_q  <= '0;
      reg_req_q   <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      exec_req_q  <= 1'b0;
      data_q      <= '0;
      data_we_q   <= 2'b00;
    end else if (!dmactive_i) begin
      // Debug module deactivated: abandon any hart handshake in flight.
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      cmderr_q    <= CMDERR_NONE;
      last_cmd_q  <= '0;
      reg_req_q   <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      exec_req_q  <= 1'b0;
      data_q      <= '0;
      data_we_q   <= 2'b00;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so later
      // statements in this block see the pre-edge values; the last
      // assignment to a register in program order wins.
      data_we_q <= 2'b00;
      cmderr_q  <= cmderr_cleared;

      // A launch while a command is running only records the collision.
      if (launch && busy_q && (cmderr_cleared == CMDERR_NONE)) begin
        cmderr_q <= CMDERR_BUSY;
      end

      case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
        end

        ST_REG: begin
          if (reg_ack_i) begin
            reg_req_q <= 1'b0;
            reg_we_q  <= 1'b0;
            if (reg_err_i) begin
              cmderr_q <= CMDERR_EXCEPT;
              state_q  <= ST_IDLE;
              busy_q   <= 1'b0;
            end else begin
              if (!cur_ar.write) begin
                data_q    <= cur_size64 ? reg_rdata_i : (reg_rdata_i & WORD_MASK);
                data_we_q <= cur_size64 ? 2'b11 : 2'b01;
              end
              if (cur_ar.aarpostincrement) begin
                last_cmd_q.control[15:0] <= cur_ar.regno + 16'd1;
              end
              if (cur_ar.postexec) begin
                state_q    <= ST_EXEC;
                exec_req_q <= 1'b1;
              end else begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
        end

        ST_EXEC: begin
          if (exec_done_i || exec_exc_i) begin
            exec_req_q <= 1'b0;
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            if (exec_exc_i) begin
              cmderr_q <= CMDERR_EXCEPT;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      // Fresh launch from an idle sequencer with no pending error.
      if (launch && !busy_q && (cmderr_cleared == CMDERR_NONE)) begin
        if (cmd_valid_i) begin
          last_cmd_q <= command_t'(cmd_i);
        end
        if (check_err != CMDERR_NONE) begin
          cmderr_q <= check_err;
        end else begin
          busy_q <= 1'b1;
          if (launch_ar.transfer) begin
            state_q     <= ST_REG;
            reg_req_q   <= 1'b1;
            reg_we_q    <= launch_ar.write;
            reg_addr_q  <= launch_ar.regno;
            reg_wdata_q <= launch_size64 ? data_i : (data_i & WORD_MASK);
          end else if (launch_ar.postexec) begin
            state_q    <= ST_EXEC;
            exec_req_q <= 1'b1;
          end
        end
      end
    end
  end

  // Reserved command bits carry no meaning for the sequencer.
  logic unused_fields;
  assign unused_fields = ^{launch_ar.zero0, cur_ar.zero0, cur_ar.transfer};

  assign busy_o      = busy_q;
  assign cmderr_o    = cmderr_q;
  assign data_o      = data_q;
  assign data_we_o   = data_we_q;
  assign reg_req_o   = reg_req_q;
  assign reg_we_o    = reg_we_q;
  assign reg_addr_o  = reg_addr_q;
  assign reg_wdata_o = reg_wdata_q;
  assign exec_req_o  = exec_req_q;

endmodule

// File: tb/tb_riscv_dm_abstract_cmd.sv
// Directed bench for the abstract-command sequencer. Stimulus pushes the
// expected hart requests, read results, exec requests and busy lengths into
// queues; a negedge monitor pops and compares them as the DUT presents them.
module tb_riscv_dm_abstract_cmd;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rstn;
  logic            dmactive;
  logic            halted;
  logic            cmd_valid;
  logic [31:0]     cmd;
  logic            autoexec;
  logic [2:0]      cmderr_clr;
  logic            busy;
  logic [2:0]      cmderr;
  logic [XLEN-1:0] data_in;
  logic [XLEN-1:0] data_out;
  logic [1:0]      data_we;
  logic            reg_req;
  logic            reg_we;
  logic [15:0]     reg_addr;
  logic [XLEN-1:0] reg_wdata;
  logic            reg_ack;
  logic [XLEN-1:0] reg_rdata;
  logic            reg_err;
  logic            exec_req;
  logic            exec_done;
  logic            exec_exc;

  always #5 clk = ~clk;

  riscv_dm_abstract_cmd #(.XLEN(XLEN)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .dmactive_i   (dmactive),
    .halted_i     (halted),
    .cmd_valid_i  (cmd_valid),
    .cmd_i        (cmd),
    .autoexec_i   (autoexec),
    .cmderr_clr_i (cmderr_clr),
    .busy_o       (busy),
    .cmderr_o     (cmderr),
    .data_i       (data_in),
    .data_o       (data_out),
    .data_we_o    (data_we),
    .reg_req_o    (reg_req),
    .reg_we_o     (reg_we),
    .reg_addr_o   (reg_addr),
    .reg_wdata_o  (reg_wdata),
    .reg_ack_i    (reg_ack),
    .reg_rdata_i  (reg_rdata),
    .reg_err_i    (reg_err),
    .exec_req_o   (exec_req),
    .exec_done_i  (exec_done),
    .exec_exc_i   (exec_exc)
  );

  typedef struct {
    logic            we;
    logic [15:0]     addr;
    logic [XLEN-1:0] wdata;
  } reg_exp_t;

  typedef struct {
    logic [1:0]      we;
    logic [XLEN-1:0] data;
  } data_exp_t;

  reg_exp_t  reg_q[$];
  data_exp_t data_q[$];
  int        exec_q[$];
  int        busy_len_q[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic      prev_req  = 1'b0;
  logic      prev_exec = 1'b0;
  int        busy_cnt  = 0;
  reg_exp_t  er;
  data_exp_t ed;
  int        eb;
  int        ee;

  always @(negedge clk) begin
    if (reg_req && !prev_req) begin
      if (reg_q.size() == 0) check("reg_req unexpected", 64'(reg_req), 64'd0);
      else begin
        er = reg_q.pop_front();
        check("reg_we", 64'(reg_we), 64'(er.we));
        check("reg_addr", 64'(reg_addr), 64'(er.addr));
        check("reg_wdata", reg_wdata, er.wdata);
      end
    end
    prev_req = reg_req;

    if (data_we != 2'b00) begin
      if (data_q.size() == 0) check("data_we unexpected", 64'(data_we), 64'd0);
      else begin
        ed = data_q.pop_front();
        check("data_we", 64'(data_we), 64'(ed.we));
        // A 32-bit read only defines the low word of data_o.
        if (ed.we == 2'b01) check("data_o low", data_out & 64'hFFFF_FFFF, ed.data & 64'hFFFF_FFFF);
        else                check("data_o", data_out, ed.data);
      end
    end

    if (exec_req && !prev_exec) begin
      if (exec_q.size() == 0) check("exec_req unexpected", 64'(exec_req), 64'd0);
      else ee = exec_q.pop_front();
    end
    prev_exec = exec_req;

    if (busy) busy_cnt++;
    else if (busy_cnt > 0) begin
      if (busy_len_q.size() == 0) check("busy unexpected", 64'(busy_cnt), 64'd0);
      else begin
        eb = busy_len_q.pop_front();
        check("busy cycles", 64'(busy_cnt), 64'(eb));
      end
      busy_cnt = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_reg(input logic we, input logic [15:0] addr, input logic [63:0] wdata);
    reg_exp_t e;
    e.we = we; e.addr = addr; e.wdata = wdata;
    reg_q.push_back(e);
  endtask

  task automatic push_data(input logic [1:0] we, input logic [63:0] d);
    data_exp_t e;
    e.we = we; e.data = d;
    data_q.push_back(e);
  endtask

  task automatic launch_cmd(input logic [31:0] c, input logic [2:0] clr);
    @(negedge clk);
    cmd_valid = 1'b1; cmd = c; cmderr_clr = clr;
    @(negedge clk);
    cmd_valid = 1'b0; cmderr_clr = 3'd0;
  endtask

  task automatic autoexec_pulse();
    @(negedge clk);
    autoexec = 1'b1;
    @(negedge clk);
    autoexec = 1'b0;
  endtask

  task automatic clr_pulse(input logic [2:0] m);
    @(negedge clk);
    cmderr_clr = m;
    @(negedge clk);
    cmderr_clr = 3'd0;
  endtask

  // Waits for a register request, lets `lat` cycles pass, then acks once.
  task automatic respond_reg(input logic [63:0] rdata, input logic err, input int lat);
    int n = 0;
    while (!reg_req && n < 20) begin @(negedge clk); n++; end
    if (!reg_req) check("reg_req timeout", 64'(reg_req), 64'd1);
    else begin
      repeat (lat) @(negedge clk);
      reg_ack = 1'b1; reg_rdata = rdata; reg_err = err;
      @(negedge clk);
      reg_ack = 1'b0; reg_err = 1'b0;
    end
  endtask

  task automatic respond_exec(input logic exc, input int lat);
    int n = 0;
    while (!exec_req && n < 20) begin @(negedge clk); n++; end
    if (!exec_req) check("exec_req timeout", 64'(exec_req), 64'd1);
    else begin
      repeat (lat) @(negedge clk);
      if (exc) exec_exc = 1'b1; else exec_done = 1'b1;
      @(negedge clk);
      exec_exc = 1'b0; exec_done = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin @(negedge clk); n++; end
    check("idle timeout", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rstn = 1'b0; dmactive = 1'b1; halted = 1'b1;
    cmd_valid = 1'b0; cmd = '0; autoexec = 1'b0; cmderr_clr = 3'd0;
    data_in = '0; reg_ack = 1'b0; reg_rdata = '0; reg_err = 1'b0;
    exec_done = 1'b0; exec_exc = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst busy", 64'(busy), 64'd0);
    check("rst cmderr", 64'(cmderr), 64'd0);
    check("rst reg_req", 64'(reg_req), 64'd0);
    check("rst exec_req", 64'(exec_req), 64'd0);
    check("rst data_o", data_out, 64'd0);
    check("rst reg_addr", 64'(reg_addr), 64'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("post-rst busy", 64'(busy), 64'd0);

    // Halted GPR read of x1, size 2: low word lands in data0.
    push_reg(1'b0, 16'h1001, 64'd0);
    push_data(2'b01, 64'h0000_0000_1234_5678);
    busy_len_q.push_back(2);
    launch_cmd(32'h0022_1001, 3'd0);
    respond_reg(64'hDEAD_BEEF_1234_5678, 1'b0, 1);
    wait_idle();
    check("gpr read cmderr", 64'(cmderr), 64'd0);

    // 64-bit write of x5 with postincrement and postexec (aarsize 3, bits 19..16 = 1111).
    data_in = 64'hA5A5_A5A5_5A5A_5A5A;
    push_reg(1'b1, 16'h1005, 64'hA5A5_A5A5_5A5A_5A5A);
    exec_q.push_back(1);
    busy_len_q.push_back(4);
    launch_cmd(32'h003F_1005, 3'd0);
    respond_reg(64'd0, 1'b0, 1);
    respond_exec(1'b0, 1);
    wait_idle();
    // autoexec re-issues the stored command at the incremented regno.
    push_reg(1'b1, 16'h1006, 64'hA5A5_A5A5_5A5A_5A5A);
    exec_q.push_back(1);
    busy_len_q.push_back(4);
    autoexec_pulse();
    respond_reg(64'd0, 1'b0, 1);
    respond_exec(1'b0, 1);
    wait_idle();
    check("postinc cmderr", 64'(cmderr), 64'd0);

    // 32-bit write of x8: upper half of the write data is zero.
    data_in = 64'hFFFF_0000_1234_ABCD;
    push_reg(1'b1, 16'h1008, 64'h0000_0000_1234_ABCD);
    busy_len_q.push_back(2);
    launch_cmd(32'h0023_1008, 3'd0);
    respond_reg(64'd0, 1'b0, 1);
    wait_idle();
    data_in = '0;

    // Busy collision: second COMMAND during REG is dropped, cmderr 1.
    push_reg(1'b0, 16'h1002, 64'd0);
    push_data(2'b01, 64'h0000_0000_0BAD_F00D);
    busy_len_q.push_back(2);
    launch_cmd(32'h0022_1002, 3'd0);
    cmd_valid = 1'b1; cmd = 32'h0022_1003;
    @(negedge clk);
    cmd_valid = 1'b0;
    reg_ack = 1'b1; reg_rdata = 64'h0000_0000_0BAD_F00D;
    @(negedge clk);
    reg_ack = 1'b0;
    wait_idle();
    check("collision cmderr", 64'(cmderr), 64'd1);
    clr_pulse(3'd7);
    check("collision cleared", 64'(cmderr), 64'd0);
    // Stored command is still the first one (x2).
    push_reg(1'b0, 16'h1002, 64'd0);
    push_data(2'b01, 64'h0000_0000_1111_2222);
    busy_len_q.push_back(2);
    autoexec_pulse();
    respond_reg(64'h0000_0000_1111_2222, 1'b0, 1);
    wait_idle();

    // Running hart: cmderr 4 visible right after the launch edge, no busy.
    halted = 1'b0;
    launch_cmd(32'h0022_1001, 3'd0);
    check("running cmderr", 64'(cmderr), 64'd4);
    check("running busy", 64'(busy), 64'd0);
    halted = 1'b1;
    // Further commands are ignored while cmderr is set.
    launch_cmd(32'h0022_1001, 3'd0);
    repeat (2) @(negedge clk);
    check("ignored cmderr", 64'(cmderr), 64'd4);
    check("ignored busy", 64'(busy), 64'd0);
    clr_pulse(3'd3);
    check("partial clr", 64'(cmderr), 64'd4);
    clr_pulse(3'd7);
    check("full clr", 64'(cmderr), 64'd0);

    // Unsupported size 4.
    launch_cmd(32'h0042_1001, 3'd0);
    check("size4 cmderr", 64'(cmderr), 64'd2);
    clr_pulse(3'd7);
    // Unsupported cmdtype 1.
    launch_cmd(32'h0100_0000, 3'd0);
    check("cmdtype cmderr", 64'(cmderr), 64'd2);
    // Clear and launch in the same cycle: clear applies first, x31 accepted.
    push_reg(1'b0, 16'h101F, 64'd0);
    push_data(2'b01, 64'h0000_0000_0000_0001);
    busy_len_q.push_back(2);
    launch_cmd(32'h0022_101F, 3'd7);
    respond_reg(64'h0000_0000_0000_0001, 1'b0, 1);
    wait_idle();
    check("x31 cmderr", 64'(cmderr), 64'd0);
    // First regno past the GPR range.
    launch_cmd(32'h0022_1020, 3'd0);
    check("regno range cmderr", 64'(cmderr), 64'd2);
    clr_pulse(3'd7);
    // No transfer: regno is not checked, busy for a single cycle.
    busy_len_q.push_back(1);
    launch_cmd(32'h0000_2000, 3'd0);
    wait_idle();
    check("no-transfer cmderr", 64'(cmderr), 64'd0);

    // Register fault: cmderr 3 and the postexec is skipped.
    push_reg(1'b0, 16'h1001, 64'd0);
    busy_len_q.push_back(2);
    launch_cmd(32'h0026_1001, 3'd0);
    respond_reg(64'h1234, 1'b1, 1);
    wait_idle();
    check("reg_err cmderr", 64'(cmderr), 64'd3);
    clr_pulse(3'd7);

    // Exception during program buffer: cmderr 3, busy drops.
    exec_q.push_back(1);
    busy_len_q.push_back(2);
    launch_cmd(32'h0004_0000, 3'd0);
    respond_exec(1'b1, 1);
    wait_idle();
    check("exec_exc cmderr", 64'(cmderr), 64'd3);
    check("exec_exc exec_req", 64'(exec_req), 64'd0);
    clr_pulse(3'd7);

    // Abort mid-EXEC by dropping dmactive; a late done is ignored.
    exec_q.push_back(1);
    busy_len_q.push_back(1);
    launch_cmd(32'h0004_0000, 3'd0);
    dmactive = 1'b0;
    @(negedge clk);
    dmactive = 1'b1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort exec_req", 64'(exec_req), 64'd0);
    check("abort cmderr", 64'(cmderr), 64'd0);
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    repeat (2) @(negedge clk);
    check("late done busy", 64'(busy), 64'd0);
    check("late done exec_req", 64'(exec_req), 64'd0);
    // Stored command was cleared: autoexec runs a no-op for one busy cycle.
    busy_len_q.push_back(1);
    autoexec_pulse();
    wait_idle();

    // Asynchronous reset in the middle of REG clears outputs at once.
    push_reg(1'b0, 16'h1001, 64'd0);
    busy_len_q.push_back(1);
    launch_cmd(32'h0022_1001, 3'd0);
    #2 rstn = 1'b0;
    #1;
    check("async rst busy", 64'(busy), 64'd0);
    check("async rst reg_req", 64'(reg_req), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("after rst reg_req", 64'(reg_req), 64'd0);

    check("reg_q drained", 64'(reg_q.size()), 64'd0);
    check("data_q drained", 64'(data_q.size()), 64'd0);
    check("exec_q drained", 64'(exec_q.size()), 64'd0);
    check("busy_q drained", 64'(busy_len_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
